// File: rtl/noc_output_arbiter_pkg.sv
// Shared flit format and arbiter state encoding for the output-direction switch allocator.
// Flit bits [15:14] carry the wormhole type and the remaining bits carry the payload.
package noc_output_arbiter_pkg;

    localparam int FLIT_W    = 16;
    localparam int PAYLOAD_W = FLIT_W - 2;

    typedef enum logic [1:0] {
        BODY   = 2'b00,
        HEAD   = 2'b01,
        TAIL   = 2'b10,
        SINGLE = 2'b11
    } flit_type_e;

    typedef struct packed {
        flit_type_e            ftype;
        logic [PAYLOAD_W-1:0]  payload;
    } flit_t;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

    // BODY or TAIL flits reaching an unlocked output belong to no packet.
    function automatic logic isOrphan(input flit_type_e t);
        return (t == BODY) || (t == TAIL);
    endfunction

endpackage

// File: rtl/noc_output_arbiter_if.sv
// Input-port head-flit bus plus output link of one router output direction.
// The master modport is the arbiter; the slave modport is the surrounding router/link.
interface noc_output_arbiter_if #(parameter int NUM_IN = 5);
    import noc_output_arbiter_pkg::*;

    logic [NUM_IN*FLIT_W-1:0] in_data_i;
    logic [NUM_IN-1:0]        in_valid_i;
    logic [NUM_IN-1:0]        req_i;
    logic [NUM_IN-1:0]        shift_o;
    logic [FLIT_W-1:0]        data_o;
    logic                     valid_o;
    logic                     ready_i;
    logic                     err_o;

    modport master (
        input  in_data_i, in_valid_i, req_i, ready_i,
        output shift_o, data_o, valid_o, err_o
    );

    modport slave (
        output in_data_i, in_valid_i, req_i, ready_i,
        input  shift_o, data_o, valid_o, err_o
    );

endinterface

// File: rtl/noc_output_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first requesting index after ptr_i, wrapping modulo N.
// The pointer itself lives in the caller so it can advance per packet rather than per grant.
module noc_rr_arbiter #(
    parameter int N     = 5,
    parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req_i,
    input  logic [PTR_W-1:0] ptr_i,
    output logic [PTR_W-1:0] grantIdx_o,
    output logic             grantValid_o
);

    logic [PTR_W-1:0] idx;

    // Scan farthest-first so the nearest requester after the pointer overwrites any earlier hit.
    always_comb begin
        grantIdx_o   = '0;
        grantValid_o = 1'b0;
        idx          = '0;
        for (int i = N; i >= 1; i--) begin
            idx = PTR_W'((int'(ptr_i) + i) % N);
            if (req_i[idx]) begin
                grantIdx_o   = idx;
                grantValid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/noc_output_arbiter.sv
// Wormhole switch allocator for one output: round-robin over input heads, locks to a packet
// from HEAD to TAIL, pops the chosen FIFO and registers the flit onto the output link.
module noc_output_arbiter
    import noc_output_arbiter_pkg::*;
#(
    parameter int NUM_IN = 5
) (
    input logic                  clk,
    input logic                  rst,
    noc_output_arbiter_if.master bus
);

    localparam int PTR_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;

    arb_state_e       state_q, state_d;
    logic [PTR_W-1:0] owner_q, owner_d;
    logic [PTR_W-1:0] rrPtr_q, rrPtr_d;
    flit_t            data_q, data_d;
    logic             valid_q, valid_d;
    logic             err_q, err_d;

    logic [PTR_W-1:0] winIdx, selIdx;
    logic             winValid, outFree, doXfer;
    flit_t            selFlit;
    logic [NUM_IN-1:0] shift;

    noc_rr_arbiter #(.N(NUM_IN), .PTR_W(PTR_W)) uRrArbiter (
        .req_i        (bus.req_i & bus.in_valid_i),
        .ptr_i        (rrPtr_q),
        .grantIdx_o   (winIdx),
        .grantValid_o (winValid)
    );

    assign outFree = !valid_q || bus.ready_i;
    assign selIdx  = (state_q == LOCKED) ? owner_q : winIdx;
    assign selFlit = flit_t'(bus.in_data_i[selIdx*FLIT_W +: FLIT_W]);
    assign doXfer  = outFree && ((state_q == LOCKED) ? bus.in_valid_i[owner_q] : winValid);

    // Malformed flits are still forwarded so the link never stalls; err_d flags them for one cycle.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        rrPtr_d = rrPtr_q;
        data_d  = data_q;
        valid_d = valid_q;
        err_d   = 1'b0;
        shift   = '0;
        if (outFree) begin
            valid_d = 1'b0;
        end
        if (doXfer) begin
            shift[selIdx] = 1'b1;
            data_d        = selFlit;
            valid_d       = 1'b1;
            if (state_q == IDLE) begin
                if (selFlit.ftype == HEAD) begin
                    state_d = LOCKED;
                    owner_d = selIdx;
                end else begin
                    rrPtr_d = selIdx;
                    err_d   = isOrphan(selFlit.ftype);
                end
            end else begin
                case (selFlit.ftype)
                    TAIL: begin
                        state_d = IDLE;
                        rrPtr_d = owner_q;
                    end
                    BODY:    ;
                    default: err_d = 1'b1;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            owner_q <= '0;
            rrPtr_q <= PTR_W'(NUM_IN - 1);
            data_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            rrPtr_q <= rrPtr_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    assign bus.shift_o = rst ? '0 : shift;
    assign bus.data_o  = data_q;
    assign bus.valid_o = valid_q;
    assign bus.err_o   = err_q;

endmodule

// File: tb/tb_noc_output_arbiter.sv
// Bench for noc_output_arbiter: directed vector table, multi-cycle corner sequences and
// randomized traffic compared against a packet-level reference model.
module tb_noc_output_arbiter;
    import noc_output_arbiter_pkg::*;

    localparam int NP = 5;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    noc_output_arbiter_if #(.NUM_IN(NP)) bus ();
    noc_output_arbiter #(.NUM_IN(NP)) dut (.clk(clk), .rst(rst), .bus(bus));

    int checks   = 0;
    int failures = 0;

    int          mOwner;
    int          mPtr;
    logic [15:0] mData;
    logic        mValid;
    logic        mErr;

    logic [4:0]  obsShift;
    logic [15:0] obsData;
    logic        obsValid;
    logic        obsErr;

    typedef struct packed {
        logic [4:0]  valid;
        logic [4:0]  req;
        logic [79:0] data;
        logic        ready;
        logic [4:0]  expShift;
        logic [15:0] expData;
        logic        expValid;
        logic        expErr;
    } vec_t;

    vec_t vecs [12];

    function automatic logic [79:0] put(input logic [79:0] base, input int port, input logic [15:0] f);
        logic [79:0] r;
        r = base;
        r[port*16 +: 16] = f;
        return r;
    endfunction

    function automatic vec_t mkVec(input logic [4:0] v, input logic [4:0] r, input logic [79:0] d,
                                   input logic rdy, input logic [4:0] es, input logic [15:0] ed,
                                   input logic ev, input logic ee);
        vec_t x;
        x.valid = v; x.req = r; x.data = d; x.ready = rdy;
        x.expShift = es; x.expData = ed; x.expValid = ev; x.expErr = ee;
        return x;
    endfunction

    task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic modelReset();
        mOwner = -1;
        mPtr   = NP - 1;
        mData  = '0;
        mValid = 1'b0;
        mErr   = 1'b0;
    endtask

    // Which port should pop this cycle, or -1: the packet owner if any, else round-robin after mPtr.
    function automatic int modelPick(input logic [4:0] v, input logic [4:0] r, input logic rdy);
        if (mValid && !rdy) return -1;
        if (mOwner >= 0) return v[mOwner] ? mOwner : -1;
        for (int i = 1; i <= NP; i++) begin
            int p;
            p = (mPtr + i) % NP;
            if (v[p] && r[p]) return p;
        end
        return -1;
    endfunction

    task automatic applyStimulus(input logic [4:0] v, input logic [4:0] r, input logic [79:0] d, input logic rdy);
        bus.in_valid_i = v;
        bus.req_i      = r;
        bus.in_data_i  = d;
        bus.ready_i    = rdy;
    endtask

    // One clock: drive at posedge+1, check shift at negedge, check registered outputs at posedge+1.
    task automatic stepCycle(input logic [4:0] v, input logic [4:0] r, input logic [79:0] d, input logic rdy);
        int          pick;
        logic [4:0]  expShift;
        logic [15:0] f;
        applyStimulus(v, r, d, rdy);
        #4;
        pick     = modelPick(v, r, rdy);
        expShift = (pick >= 0) ? 5'(1 << pick) : 5'b0;
        obsShift = bus.shift_o;
        checkOutput("model shift_o", 16'(obsShift), 16'(expShift));
        @(posedge clk);
        mErr = 1'b0;
        if (!mValid || rdy) begin
            if (pick >= 0) begin
                f      = d[pick*16 +: 16];
                mData  = f;
                mValid = 1'b1;
                if (mOwner < 0) begin
                    if (f[15:14] == 2'b01) mOwner = pick;
                    else begin
                        mPtr = pick;
                        mErr = (f[15:14] == 2'b00) || (f[15:14] == 2'b10);
                    end
                end else if (f[15:14] == 2'b10) begin
                    mPtr   = mOwner;
                    mOwner = -1;
                end else if ((f[15:14] == 2'b01) || (f[15:14] == 2'b11)) begin
                    mErr = 1'b1;
                end
            end else begin
                mValid = 1'b0;
            end
        end
        #1;
        obsData  = bus.data_o;
        obsValid = bus.valid_o;
        obsErr   = bus.err_o;
        checkOutput("model data_o", obsData, mData);
        checkOutput("model valid_o", 16'(obsValid), 16'(mValid));
        checkOutput("model err_o", 16'(obsErr), 16'(mErr));
    endtask

    initial begin
        logic [79:0] d;
        logic [4:0]  rv, rr;
        logic        rdy;

        vecs[0]  = mkVec(5'b01010, 5'b01010, put(put('0, 1, 16'hC001), 3, 16'hC003), 1'b1, 5'b00010, 16'hC001, 1'b1, 1'b0);
        vecs[1]  = mkVec(5'b01000, 5'b01000, put('0, 3, 16'hC003), 1'b1, 5'b01000, 16'hC003, 1'b1, 1'b0);
        vecs[2]  = mkVec(5'b00000, 5'b00000, '0, 1'b1, 5'b00000, 16'hC003, 1'b0, 1'b0);
        vecs[3]  = mkVec(5'b00100, 5'b00100, put('0, 2, 16'h4002), 1'b1, 5'b00100, 16'h4002, 1'b1, 1'b0);
        vecs[4]  = mkVec(5'b00101, 5'b00001, put(put('0, 2, 16'h0005), 0, 16'hC000), 1'b1, 5'b00100, 16'h0005, 1'b1, 1'b0);
        vecs[5]  = mkVec(5'b00101, 5'b00101, put(put('0, 2, 16'h8002), 0, 16'hC000), 1'b1, 5'b00100, 16'h8002, 1'b1, 1'b0);
        vecs[6]  = mkVec(5'b00001, 5'b00001, put('0, 0, 16'hC000), 1'b1, 5'b00001, 16'hC000, 1'b1, 1'b0);
        vecs[7]  = mkVec(5'b00000, 5'b00000, '0, 1'b1, 5'b00000, 16'hC000, 1'b0, 1'b0);
        vecs[8]  = mkVec(5'b00010, 5'b00010, put('0, 1, 16'h0011), 1'b1, 5'b00010, 16'h0011, 1'b1, 1'b1);
        vecs[9]  = mkVec(5'b00000, 5'b00000, '0, 1'b1, 5'b00000, 16'h0011, 1'b0, 1'b0);
        vecs[10] = mkVec(5'b01000, 5'b01000, put('0, 3, 16'hC003), 1'b1, 5'b01000, 16'hC003, 1'b1, 1'b0);
        vecs[11] = mkVec(5'b00001, 5'b00000, put('0, 0, 16'hC000), 1'b1, 5'b00000, 16'hC003, 1'b0, 1'b0);

        rst = 1'b1;
        applyStimulus('0, '0, '0, 1'b1);
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset valid_o", 16'(bus.valid_o), 16'h0);
        checkOutput("reset data_o", bus.data_o, 16'h0);
        checkOutput("reset err_o", 16'(bus.err_o), 16'h0);
        checkOutput("reset shift_o", 16'(bus.shift_o), 16'h0);
        rst = 1'b0;

        foreach (vecs[i]) begin
            stepCycle(vecs[i].valid, vecs[i].req, vecs[i].data, vecs[i].ready);
            checkOutput($sformatf("vec%0d shift_o", i), 16'(obsShift), 16'(vecs[i].expShift));
            checkOutput($sformatf("vec%0d data_o", i), obsData, vecs[i].expData);
            checkOutput($sformatf("vec%0d valid_o", i), 16'(obsValid), 16'(vecs[i].expValid));
            checkOutput($sformatf("vec%0d err_o", i), 16'(obsErr), 16'(vecs[i].expErr));
        end

        $display("[TB] backpressure hold");
        stepCycle(5'b10000, 5'b10000, put('0, 4, 16'h4004), 1'b0);
        for (int i = 0; i < 4; i++) begin
            stepCycle(5'b10000, 5'b10000, put('0, 4, 16'h0044), 1'b0);
            checkOutput("hold shift_o", 16'(obsShift), 16'h0);
            checkOutput("hold data_o", obsData, 16'h4004);
        end
        stepCycle(5'b10000, 5'b10000, put('0, 4, 16'h0044), 1'b1);
        checkOutput("release shift_o", 16'(obsShift), 16'(5'b10000));
        checkOutput("release data_o", obsData, 16'h0044);
        stepCycle(5'b10000, 5'b10000, put('0, 4, 16'h8004), 1'b1);
        stepCycle('0, '0, '0, 1'b1);

        $display("[TB] owner starvation bubble");
        stepCycle(5'b00001, 5'b00001, put('0, 0, 16'h4000), 1'b1);
        for (int i = 0; i < 3; i++) begin
            stepCycle(5'b10000, 5'b10000, put('0, 4, 16'hC004), 1'b1);
            checkOutput("bubble shift_o", 16'(obsShift), 16'h0);
            checkOutput("bubble valid_o", 16'(obsValid), 16'h0);
        end
        stepCycle(5'b10001, 5'b10001, put(put('0, 0, 16'h8000), 4, 16'hC004), 1'b1);
        checkOutput("resume shift_o", 16'(obsShift), 16'(5'b00001));
        checkOutput("resume data_o", obsData, 16'h8000);
        stepCycle(5'b10000, 5'b10000, put('0, 4, 16'hC004), 1'b1);
        checkOutput("after tail shift_o", 16'(obsShift), 16'(5'b10000));
        stepCycle('0, '0, '0, 1'b1);

        $display("[TB] mid-packet reset");
        stepCycle(5'b00100, 5'b00100, put('0, 2, 16'h4002), 1'b1);
        d = '0;
        for (int k = 0; k < NP; k++) d = put(d, k, 16'hC000 | 16'(k));
        d = put(d, 2, 16'h0022);
        applyStimulus(5'b11111, 5'b11111, d, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("async reset valid_o", 16'(bus.valid_o), 16'h0);
        checkOutput("async reset data_o", bus.data_o, 16'h0);
        checkOutput("async reset shift_o", 16'(bus.shift_o), 16'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        modelReset();
        stepCycle(5'b11111, 5'b11111, d, 1'b1);
        checkOutput("post-reset winner", 16'(obsShift), 16'(5'b00001));
        stepCycle('0, '0, '0, 1'b1);

        $display("[TB] randomized traffic");
        for (int n = 0; n < 400; n++) begin
            rv  = 5'($urandom);
            rr  = 5'($urandom);
            rdy = ($urandom_range(0, 3) != 0);
            d   = '0;
            for (int k = 0; k < NP; k++)
                d = put(d, k, {2'($urandom_range(0, 3)), 14'($urandom)});
            stepCycle(rv, rr, d, rdy);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
